// File: rtl/wave_rom_sched_pkg.sv
// rtl/wave_rom_sched_pkg.sv - shared types and defaults for the waveform ROM scheduler
package wave_sched_pkg;

  localparam int DEF_N_SAMPLES = 100;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_NUM_CH    = 4;
  // Tag channel field is sized for the largest supported channel count (8).
  localparam int TAG_CW        = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } sched_state_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_CW-1:0] ch;
  } tag_t;

endpackage

// File: rtl/wave_rom_sched_if.sv
// rtl/wave_rom_sched_if.sv - request/grant, config, ROM and sample-out bundle
interface wave_rom_sched_if
  import wave_sched_pkg::*;
#(
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_CH    = DEF_NUM_CH
);
  localparam int AW = $clog2(N_SAMPLES);
  localparam int CW = $clog2(NUM_CH);

  logic              run;
  logic              phase_clr;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] gnt;
  logic              cfg_we;
  logic [CW-1:0]     cfg_ch;
  logic [AW-1:0]     cfg_step;
  logic              rom_rd;
  logic [AW-1:0]     rom_addr;
  logic [WIDTH-1:0]  rom_data;
  logic              out_valid;
  logic [CW-1:0]     out_ch;
  logic [WIDTH-1:0]  out_data;
  logic              busy;

  modport master (
    output run, phase_clr, req, cfg_we, cfg_ch, cfg_step, rom_data,
    input  gnt, rom_rd, rom_addr, out_valid, out_ch, out_data, busy
  );

  modport slave (
    input  run, phase_clr, req, cfg_we, cfg_ch, cfg_step, rom_data,
    output gnt, rom_rd, rom_addr, out_valid, out_ch, out_data, busy
  );

endinterface

// File: rtl/wave_rom_sched_rr_arbiter.sv
// rtl/wave_rom_sched_rr_arbiter.sv - round-robin arbiter over channels FIRST..NUM_CH-1
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int FIRST  = 0
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      en,
  input  logic [NUM_CH-1:0]         req,
  output logic [NUM_CH-1:0]         gnt,
  output logic [$clog2(NUM_CH)-1:0] idx,
  output logic                      found
);
  localparam int CW   = $clog2(NUM_CH);
  localparam int SPAN = NUM_CH - FIRST;
  localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_CH - 1);
  localparam logic [CW-1:0] FIRST_IDX = CW'(FIRST);

  logic [CW-1:0] ptr_q, ptr_d;
  int            c;

  always_comb begin
    gnt   = '0;
    idx   = ptr_q;
    found = 1'b0;
    c     = 0;
    for (int off = 0; off < SPAN; off++) begin
      c = int'(ptr_q) + off;
      if (c >= NUM_CH) c = c - SPAN;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = CW'(c);
      end
    end
    ptr_d = ptr_q;
    if (en && found) ptr_d = (idx == LAST_IDX) ? FIRST_IDX : idx + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!nreset) ptr_q <= FIRST_IDX;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wave_rom_sched.sv
// rtl/wave_rom_sched.sv - round-robin sharing of one sample ROM among phase-accumulator channels
// WAVE_ROM_SCHED_PRIO_EN gives channel 0 fixed priority over the rotating channels.
module wave_rom_sched
  import wave_sched_pkg::*;
#(
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_CH    = DEF_NUM_CH
) (
  input logic             clock_fgen,
  input logic             nreset,
  wave_rom_sched_if.slave bus
);
  localparam int AW  = $clog2(N_SAMPLES);
  localparam int CW  = $clog2(NUM_CH);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] NS_EXT = AW1'(N_SAMPLES);
`ifdef WAVE_ROM_SCHED_PRIO_EN
  localparam int RR_FIRST = 1;
`else
  localparam int RR_FIRST = 0;
`endif

  sched_state_e      state_q, state_d;
  logic [AW-1:0]     phase_q [NUM_CH];
  logic [AW-1:0]     phase_d [NUM_CH];
  logic [AW-1:0]     step_q  [NUM_CH];
  logic [AW-1:0]     step_d  [NUM_CH];
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic              rom_rd_q, rom_rd_d;
  logic [AW-1:0]     rom_addr_q, rom_addr_d;
  tag_t              tag1_q, tag1_d, tag2_q, tag2_d;
  logic              out_valid_q, out_valid_d;
  logic [CW-1:0]     out_ch_q, out_ch_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;

  logic              grant_en, grant_any, arb_en, arb_found, sel_found;
  logic [NUM_CH-1:0] arb_req, arb_gnt, sel_onehot;
  logic [CW-1:0]     arb_idx, sel_idx;
  logic [AW:0]       sum;

  rr_arbiter #(.NUM_CH(NUM_CH), .FIRST(RR_FIRST)) u_arb (
    .clk    (clock_fgen),
    .nreset (nreset),
    .en     (arb_en),
    .req    (arb_req),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .found  (arb_found)
  );

  always_comb begin
    grant_en = (state_q == RUN) && bus.run;
`ifdef WAVE_ROM_SCHED_PRIO_EN
    // Channel 0 bypasses the arbiter; the rotation only advances when it is idle.
    arb_req    = {bus.req[NUM_CH-1:1], 1'b0};
    arb_en     = grant_en && !bus.req[0];
    sel_found  = bus.req[0] || arb_found;
    sel_idx    = bus.req[0] ? '0 : arb_idx;
    sel_onehot = bus.req[0] ? NUM_CH'(1) : arb_gnt;
`else
    arb_req    = bus.req;
    arb_en     = grant_en;
    sel_found  = arb_found;
    sel_idx    = arb_idx;
    sel_onehot = arb_gnt;
`endif
    grant_any = grant_en && sel_found;
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    step_d      = step_q;
    sum         = {1'b0, phase_q[sel_idx]} + {1'b0, step_q[sel_idx]};
    gnt_d       = grant_any ? sel_onehot : '0;
    rom_rd_d    = grant_any;
    rom_addr_d  = grant_any ? phase_q[sel_idx] : rom_addr_q;
    tag1_d      = '{valid: grant_any, ch: TAG_CW'(sel_idx)};
    tag2_d      = tag1_q;
    out_valid_d = tag2_q.valid;
    out_ch_d    = tag2_q.valid ? CW'(tag2_q.ch) : out_ch_q;
    out_data_d  = tag2_q.valid ? bus.rom_data : out_data_q;

    unique case (state_q)
      IDLE:    if (bus.run) state_d = RUN;
      RUN:     if (!bus.run) state_d = DRAIN;
      DRAIN:   if (bus.run) state_d = RUN;
               else if (!tag1_q.valid && !tag2_q.valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (grant_any) phase_d[sel_idx] = (sum >= NS_EXT) ? AW'(sum - NS_EXT) : sum[AW-1:0];
    if (bus.phase_clr) phase_d = '{default: '0};
    if (bus.cfg_we) step_d[bus.cfg_ch] = bus.cfg_step;
  end

  always_ff @(posedge clock_fgen) begin
    if (!nreset) begin
      state_q     <= IDLE;
      phase_q     <= '{default: '0};
      step_q      <= '{default: AW'(1)};
      gnt_q       <= '0;
      rom_rd_q    <= 1'b0;
      rom_addr_q  <= '0;
      tag1_q      <= '0;
      tag2_q      <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      step_q      <= step_d;
      gnt_q       <= gnt_d;
      rom_rd_q    <= rom_rd_d;
      rom_addr_q  <= rom_addr_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rom_rd    = rom_rd_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
